// File: rtl/instr_mem_loader.sv
// Boot loader: byte stream -> little-endian words -> instruction memory.
// Header gives word count N; done/error gate the core's release from reset.
module instr_mem_loader #(
  parameter int DEPTH_WORDS = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0]      DEPTH_W = 32'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [1:0]       byte_cnt;
  logic [31:0]      hdr;
  logic [31:0]      hdr_full;
  logic [31:0]      word_buf;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] n_words;
  logic             accept;
  logic             last_byte;
  logic             clear;
  logic             commit;
  logic             loading;

  assign hdr_full  = {in_data, hdr[31:8]};
  assign n_words   = CNT_W'(hdr);
  assign loading   = (state == S_HDR) || (state == S_DATA);
  assign in_ready  = rst && loading;
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign commit    = (state == S_WRITE);
  assign clear     = restart &&
                     ((state == S_DONE) || (state == S_ERR));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_HDR;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and memory-port decode.
  always_comb begin
    state_nx = state;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = 32'd0;
    mem_din  = 32'd0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      S_HDR: begin
        if (accept && last_byte) begin
          if (hdr_full == 32'd0) begin
            state_nx = S_DONE;
          end else if (hdr_full > DEPTH_W) begin
            state_nx = S_ERR;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && last_byte) begin
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = 32'(word_idx << 2);
        mem_din  = word_buf;
        if ((word_idx + ONE) == n_words) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_DATA;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (restart) begin
          state_nx = S_HDR;
        end
      end
      S_ERR: begin
        error = 1'b1;
        if (restart) begin
          state_nx = S_HDR;
        end
      end
      default: begin
        state_nx = S_HDR;
      end
    endcase
  end

  // Byte packing, header capture and word counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= 2'd0;
      hdr      <= 32'd0;
      word_buf <= 32'd0;
      word_idx <= '0;
      wr_cnt   <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      hdr      <= 32'd0;
      word_buf <= 32'd0;
      word_idx <= '0;
      wr_cnt   <= '0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_HDR) begin
          hdr <= hdr_full;
        end else begin
          word_buf <= {in_data, word_buf[31:8]};
        end
      end
      if (commit) begin
        word_idx <= word_idx + ONE;
        wr_cnt   <= wr_cnt + ONE;
      end
    end
  end

  assign words_written = wr_cnt;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed loads with random data/gaps,
// compared against a word-list model of the expected memory writes.
module tb_instr_mem_loader;

  localparam int DEPTH = 32;
  localparam int CW    = 32;

  logic          clk;
  logic          rst;
  logic          restart;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_en;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_din;
  logic          done;
  logic          error;
  logic [CW-1:0] words_written;

  int n_assert;
  int n_fail;

  logic [31:0] words[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  instr_mem_loader #(
    .DEPTH_WORDS(DEPTH),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .restart(restart),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .done(done),
    .error(error),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Bus monitor: record writes, check idle bus and ready/write exclusivity.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("en_eq_we", {31'd0, mem_en}, {31'd0, mem_we});
      if (mem_en) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_din);
      end else begin
        check("idle_bus", mem_addr | mem_din, 32'd0);
      end
      if (!done && !error) begin
        check("ready_vs_write", {31'd0, in_ready}, {31'd0, !mem_we});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int guard;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic rearm();
    pulse_restart();
    check("rearm_done", {31'd0, done}, 32'd0);
    check("rearm_err", {31'd0, error}, 32'd0);
    check("rearm_ww", words_written, 32'd0);
    check("rearm_rdy", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] n, input int maxgap,
                         input bit mid_restart);
    logic [7:0]  stream[$];
    logic [31:0] w;
    int nw;
    wa_q.delete();
    wd_q.delete();
    for (int k = 0; k < 4; k++) begin
      w = n >> (8 * k);
      stream.push_back(w[7:0]);
    end
    nw = (n >= 32'd1 && n <= 32'(DEPTH)) ? int'(n) : 0;
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < 4; k++) begin
        w = words[i] >> (8 * k);
        stream.push_back(w[7:0]);
      end
    end
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], maxgap);
      if (mid_restart && i == 5) pulse_restart();
    end
    if (n == 32'd0) begin
      @(negedge clk);
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_ww", words_written, 32'd0);
    end else if (nw == 0) begin
      @(negedge clk);
      check("err_flag", {31'd0, error}, 32'd1);
      check("err_done", {31'd0, done}, 32'd0);
      check("err_rdy", {31'd0, in_ready}, 32'd0);
    end else begin
      @(negedge clk);
      check("last_we", {31'd0, mem_we}, 32'd1);
      check("last_addr", mem_addr, 32'(nw - 1) << 2);
      check("last_din", mem_din, words[nw-1]);
      check("last_done_lo", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("done_rise", {31'd0, done}, 32'd1);
      check("done_ww", words_written, n);
    end
    // Bytes offered while finished must be refused.
    in_valid = 1'b1;
    in_data  = 8'h5a;
    repeat (3) @(negedge clk);
    check("hold_rdy", {31'd0, in_ready}, 32'd0);
    check("hold_flags", {30'd0, error, done},
          (nw == 0 && n != 32'd0) ? 32'd2 : 32'd1);
    check("hold_ww", words_written, 32'(nw));
    in_valid = 1'b0;
    check("wr_count", 32'(wa_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      check("wr_addr", wa_q[i], 32'(i) * 32'd4);
      check("wr_data", wd_q[i], words[i]);
    end
  endtask

  initial begin
    int n;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    restart  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_lo", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_flags", {29'd0, mem_en, done, error}, 32'd0);
    check("rst_bus", mem_addr | mem_din, 32'd0);
    check("rst_ww", words_written, 32'd0);

    words = '{32'h00000013, 32'h00100093};
    do_load(32'd2, 0, 1'b0);
    rearm();
    do_load(32'd2, 5, 1'b0);
    rearm();

    do_load(32'd33, 0, 1'b0);
    rearm();

    do_load(32'd0, 0, 1'b0);
    rearm();
    words = '{32'hDDCCBBAA};
    do_load(32'd1, 0, 1'b0);
    rearm();

    // Reset in the middle of a 3-word load.
    wa_q.delete();
    wd_q.delete();
    send_byte(8'h03, 0);
    for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    check("post_rst_ww", words_written, 32'd0);
    check("post_rst_wr", 32'(wa_q.size()), 32'd0);
    words = '{$urandom()};
    do_load(32'd1, 0, 1'b0);
    rearm();

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(8, 1));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom());
      do_load(32'(n), int'($urandom_range(3, 0)), n >= 2);
      rearm();
    end

    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom());
    do_load(32'(DEPTH), 1, 1'b0);
    rearm();

    do_load(32'h80000000, 0, 1'b0);
    rearm();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
